riscv_dmem_ctrl: RTL
====================

Name: riscv_dmem_ctrl

Overview:
Data-side memory controller directly downstream of the RISC-V core's load/store port. It decodes the core's byte address into a word-organised data RAM and a small MMIO block (GPIO, machine timer), and returns read data on ddatin. Stores use the core's read-modify-write sequence: the request cycle returns the old word, and the core's merged word on ddatout is committed one cycle later. A bus-error pulse flags bad accesses.

Parameters:
RAM_AW, 10, log2 of data RAM depth in 32-bit words (1024 words = 4 KiB)
GPIO_W, 8, width of GPIO output and input registers
MMIO_BASE, 32'h1000_0000, base byte address of MMIO window (16 bytes)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low
mem_addr  in  32  byte address from core
rw  in  1  1 = store request, 0 = load request (qualified by en)
en  in  1  request strobe, one cycle per access
ddatout  in  32  merged store word from core, valid the cycle after the request is sampled
ddatin  out  32  read word to core (combinational from mem_addr)
gpio_out  out  GPIO_W  GPIO output register
gpio_in  in  GPIO_W  asynchronous GPIO inputs
timer_irq  out  1  registered, mtime >= mtimecmp
bus_err  out  1  one-cycle pulse on decode error or protocol violation

Behaviour:
- Reset (rst=0 at an edge): state IDLE, gpio_out=0, mtime=0, mtimecmp=32'hFFFF_FFFF, timer_irq=0, bus_err=0, gpio synchroniser flops=0. RAM contents are not reset.
- Decode (mem_addr, low 2 bits ignored):
  - RAM: mem_addr[31:RAM_AW+2]==0, word index mem_addr[RAM_AW+1:2].
  - MMIO: mem_addr[31:4]==MMIO_BASE[31:4].
    - 0x0 GPIO_OUT (rw)
    - 0x4 GPIO_IN (ro, zero-extended, 2-flop synchronised)
    - 0x8 MTIME (rw)
    - 0xC MTIMECMP (rw)
  - Anything else: unmapped.
- ddatin: purely combinational from current mem_addr and storage, so it is valid in the same cycle the core holds en and sampled at the next edge. Unmapped reads give 0.
- FSM, 2 states:
  - IDLE: at an edge with en=1:
    - rw=0: no state change; if unmapped, pulse bus_err.
    - rw=1: latch word target (region + index) into commit_tgt and go to COMMIT; if unmapped or GPIO_IN, latch a discard flag and pulse bus_err.
  - COMMIT: at the next edge, write ddatout (full 32 bits) to commit_tgt unless discarded, then return to IDLE.
  - en=1 in COMMIT is a protocol violation: the commit still completes, the new request is dropped, bus_err pulses.
- Latency:
  - Load: 0 cycles (combinational).
  - Store: the RAM/register is updated at the second edge after en is driven, i.e. the edge after the request is sampled.
  - A load to the same word issued after the commit edge sees new data. No bypass is required because the core cannot re-request within COMMIT.
- Timer:
  - mtime increments by 1 every cycle and wraps 32'hFFFF_FFFF to 0.
  - A committed write to MTIME loads ddatout and overrides the increment on that edge.
  - timer_irq is registered each edge as (mtime_next >= mtimecmp_next), unsigned. It is level, cleared only by raising mtimecmp or writing mtime.
- bus_err: high for exactly one cycle per offending event, 0 otherwise.
- Reset mid-COMMIT: the pending write is abandoned and the state goes to IDLE.

Test Plan:
- Reset: hold rst=0 for 2 edges -> gpio_out=0, timer_irq=0, bus_err=0. After release, mtime reads 0, 1, 2 on successive cycles (read via mem_addr=0x1000_0008).
- RAM store/load: en=1, rw=1, mem_addr=0x0000_0010 for one cycle; next cycle ddatout=32'hDEAD_BEEF. Then a load from 0x10 -> ddatin=32'hDEAD_BEEF, bus_err never asserted.
- Byte-offset alias: load from 0x13 -> same word as 0x10. Store commit to 0x14 leaves 0x10 unchanged.
- GPIO: store 32'h0000_00A5 to 0x1000_0000 -> gpio_out=8'hA5 after the commit edge. Drive gpio_in=8'h3C -> a read of 0x1000_0004 returns 32'h3C two edges later.
- Timer: write MTIMECMP=20, then MTIME=10 -> timer_irq rises 10 cycles after the MTIME commit edge. Write MTIMECMP=32'hFFFF_FFFF -> timer_irq clears next edge.
- Errors: load from 0x2000_0000 -> ddatin=0 and one bus_err pulse. Store to 0x1000_0004 -> bus_err pulse, GPIO_IN unaffected. en=1 during COMMIT -> first commit lands, second request dropped, bus_err pulses.

Source files
------------

// File: rtl/riscv_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_dmem_ctrl
//
// Data-side memory controller that sits directly behind the RISC-V core's
// load/store port. It decodes the core's byte address into a word-organised
// data RAM and a small MMIO window (GPIO, machine timer), and returns read
// data combinationally.
//
// Stores follow the core's read-modify-write sequence. In the request cycle
// the old word is returned on ddatin. The merged word arrives on ddatout in
// the following cycle and is committed at the next edge. A one-cycle bus_err
// pulse flags unmapped accesses, stores to read-only GPIO_IN, and new requests
// that arrive while a commit is still pending.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-low reset
//   mem_addr   byte address from the core (low two bits ignored)
//   rw         1 = store, 0 = load (qualified by en)
//   en         request strobe, one cycle per access
//   ddatout    merged store word, valid the cycle after the request
//   ddatin     read word, combinational from mem_addr
//   gpio_out   GPIO output register
//   gpio_in    asynchronous GPIO inputs (2-flop synchronised)
//   timer_irq  registered (mtime >= mtimecmp)
//   bus_err    one-cycle error pulse
// -----------------------------------------------------------------------------
module riscv_dmem_ctrl #(
    parameter int          RAM_AW    = 10,
    parameter int          GPIO_W    = 8,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_addr,
    input  logic              rw,
    input  logic              en,
    input  logic [31:0]       ddatout,
    output logic [31:0]       ddatin,
    output logic [GPIO_W-1:0] gpio_out,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic              timer_irq,
    output logic              bus_err
);

    typedef enum logic {
        S_IDLE,
        S_COMMIT
    } state_e;

    typedef enum logic [2:0] {
        TGT_RAM,
        TGT_GPIO_OUT,
        TGT_GPIO_IN,
        TGT_MTIME,
        TGT_MTIMECMP,
        TGT_NONE
    } tgt_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    tgt_e                commit_tgt_q, commit_tgt_d;
    logic [RAM_AW-1:0]   commit_idx_q, commit_idx_d;
    logic                commit_discard_q, commit_discard_d;

    logic [GPIO_W-1:0]   gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0]   gpio_sync1_q, gpio_sync2_q;
    logic [31:0]         mtime_q, mtime_d;
    logic [31:0]         mtimecmp_q, mtimecmp_d;
    logic                timer_irq_q, timer_irq_d;
    logic                bus_err_q, bus_err_d;

    logic [31:0]         ram [2**RAM_AW];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic in_ram;
    logic in_mmio;
    tgt_e tgt;
    logic addr_unused;

    assign in_ram      = (mem_addr[31:RAM_AW+2] == '0);
    assign in_mmio     = (mem_addr[31:4] == MMIO_BASE[31:4]);
    // Word-organised storage: the byte offset within a word never matters.
    assign addr_unused = ^mem_addr[1:0];

    always_comb begin
        tgt = TGT_NONE;
        if (in_ram) begin
            tgt = TGT_RAM;
        end else if (in_mmio) begin
            case (mem_addr[3:2])
                2'd0:    tgt = TGT_GPIO_OUT;
                2'd1:    tgt = TGT_GPIO_IN;
                2'd2:    tgt = TGT_MTIME;
                default: tgt = TGT_MTIMECMP;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path: purely combinational so the core samples it at the same
    // edge that samples the request. Unmapped reads return zero.
    // ------------------------------------------------------------------
    always_comb begin
        ddatin = '0;
        case (tgt)
            TGT_RAM:      ddatin = ram[mem_addr[RAM_AW+1:2]];
            TGT_GPIO_OUT: ddatin = {{(32-GPIO_W){1'b0}}, gpio_out_q};
            TGT_GPIO_IN:  ddatin = {{(32-GPIO_W){1'b0}}, gpio_sync2_q};
            TGT_MTIME:    ddatin = mtime_q;
            TGT_MTIMECMP: ddatin = mtimecmp_q;
            default:      ddatin = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Request / commit FSM
    // ------------------------------------------------------------------
    logic commit_fire;

    // NOTE: every output of this block gets a default before the case
    // statement, so no path leaves a signal unassigned and no latch appears.
    always_comb begin
        state_d          = state_q;
        commit_tgt_d     = commit_tgt_q;
        commit_idx_d     = commit_idx_q;
        commit_discard_d = commit_discard_q;
        bus_err_d        = 1'b0;
        commit_fire      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    if (rw) begin
                        state_d          = S_COMMIT;
                        commit_tgt_d     = tgt;
                        commit_idx_d     = mem_addr[RAM_AW+1:2];
                        commit_discard_d = (tgt == TGT_NONE) || (tgt == TGT_GPIO_IN);
                        bus_err_d        = commit_discard_d;
                    end else begin
                        bus_err_d = (tgt == TGT_NONE);
                    end
                end
            end
            S_COMMIT: begin
                // The pending commit always completes; a request arriving now
                // is a protocol violation and is dropped.
                state_d     = S_IDLE;
                commit_fire = !commit_discard_q;
                bus_err_d   = en;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-target write strobes for the commit edge
    logic ram_we, gpio_we, mtime_we, mtimecmp_we;

    assign ram_we      = commit_fire && (commit_tgt_q == TGT_RAM);
    assign gpio_we     = commit_fire && (commit_tgt_q == TGT_GPIO_OUT);
    assign mtime_we    = commit_fire && (commit_tgt_q == TGT_MTIME);
    assign mtimecmp_we = commit_fire && (commit_tgt_q == TGT_MTIMECMP);

    // ------------------------------------------------------------------
    // Register next-state: a committed MTIME write overrides the increment,
    // and the interrupt level is computed from the values being loaded so
    // it tracks the registers without an extra cycle of lag.
    // ------------------------------------------------------------------
    always_comb begin
        gpio_out_d  = gpio_we     ? ddatout[GPIO_W-1:0] : gpio_out_q;
        mtime_d     = mtime_we    ? ddatout             : mtime_q + 32'd1;
        mtimecmp_d  = mtimecmp_we ? ddatout             : mtimecmp_q;
        timer_irq_d = (mtime_d >= mtimecmp_d);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            commit_tgt_q     <= TGT_NONE;
            commit_idx_q     <= '0;
            commit_discard_q <= 1'b0;
            gpio_out_q       <= '0;
            gpio_sync1_q     <= '0;
            gpio_sync2_q     <= '0;
            mtime_q          <= '0;
            mtimecmp_q       <= 32'hFFFF_FFFF;
            timer_irq_q      <= 1'b0;
            bus_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            commit_tgt_q     <= commit_tgt_d;
            commit_idx_q     <= commit_idx_d;
            commit_discard_q <= commit_discard_d;
            gpio_out_q       <= gpio_out_d;
            gpio_sync1_q     <= gpio_in;
            gpio_sync2_q     <= gpio_sync1_q;
            mtime_q          <= mtime_d;
            mtimecmp_q       <= mtimecmp_d;
            timer_irq_q      <= timer_irq_d;
            bus_err_q        <= bus_err_d;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block/distributed
    // RAM; reset only gates the write so a commit pending at reset is lost.
    always_ff @(posedge clk) begin
        if (rst && ram_we) begin
            ram[commit_idx_q] <= ddatout;
        end
    end

    assign gpio_out  = gpio_out_q;
    assign timer_irq = timer_irq_q;
    assign bus_err   = bus_err_q;

endmodule
